// File: rtl/uart_line_buffer_if.sv
// uart_line_buffer_if
//   Bundles the receiver-side stream, the transmitter handshake and the
//   status outputs of uart_line_buffer.
//   master : environment side (drives rx_valid/rx_data/tx_rdy)
//   slave  : buffer side (drives tx_en/tx_data/busy/dropped/fill)
//   DEPTH  : buffer capacity, sets the width of fill
interface uart_line_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_rdy;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          busy;
  logic          dropped;
  logic [PW-1:0] fill;

  modport master (
    output rx_valid, rx_data, tx_rdy,
    input  tx_en, tx_data, busy, dropped, fill
  );

  modport slave (
    input  rx_valid, rx_data, tx_rdy,
    output tx_en, tx_data, busy, dropped, fill
  );
endinterface

// File: rtl/uart_line_buffer.sv
// uart_line_buffer
//   Collects received bytes until the line terminator arrives or the buffer
//   fills, then replays the line followed by the terminator through the
//   transmitter's en/rdy handshake.
//   i_clk   : system clock (shared with UART rx/tx)
//   i_rst   : synchronous active-low reset
//   io_bus  : slave side of uart_line_buffer_if
//             in  rx_valid, rx_data, tx_rdy
//             out tx_en, tx_data, busy, dropped, fill
module uart_line_buffer #(
  parameter int          DEPTH = 16,
  parameter logic [7:0]  TERM  = 8'h0D
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_line_buffer_if.slave io_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  localparam logic [1:0] S_RECV      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_RDY  = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [7:0]    r_mem [DEPTH];
  logic          r_tx_en;
  logic [7:0]    r_tx_data;
  logic          r_dropped;
  logic          r_last_term;

  logic          w_recv;
  logic          w_store;
  logic          w_term;
  logic          w_line_done;
  logic          w_drop;
  logic          w_rd_hit;
  logic [7:0]    w_rd_byte;
  logic [7:0]    w_first_byte;

  assign w_recv      = (r_state == S_RECV);
  assign w_store     = w_recv && io_bus.rx_valid && (io_bus.rx_data != TERM) && (r_wptr < DEPTH_P);
  assign w_term      = w_recv && io_bus.rx_valid && (io_bus.rx_data == TERM);
  // The line closes on the terminator, or on the store that fills the buffer.
  assign w_line_done = w_term || (w_store && (r_wptr == LAST_P));
  // Anything not stored and not a terminator accepted in RECV is lost.
  assign w_drop      = io_bus.rx_valid && !w_store && !w_term;

  assign w_rd_hit    = (r_rptr < r_wptr);
  assign w_rd_byte   = r_mem[r_rptr[AW-1:0]];
  // First byte of a replay launched straight from RECV: an empty line sends
  // only the terminator; otherwise slot 0 already holds data (DEPTH >= 2).
  assign w_first_byte = (w_term && (r_wptr == '0)) ? TERM : r_mem[0];

  // Line storage: data only, no reset.
  always_ff @(posedge i_clk) begin
    if (w_store) r_mem[r_wptr[AW-1:0]] <= io_bus.rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_RECV;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_tx_en     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_dropped   <= 1'b0;
      r_last_term <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      if (w_drop) r_dropped <= 1'b1;

      case (r_state)
        S_RECV: begin
          if (w_store) r_wptr <= r_wptr + ONE_P;
          if (w_line_done) begin
            r_rptr <= '0;
            // With the transmitter already idle, launch the first byte in the
            // closing cycle so tx_en follows the terminator by one clock.
            if (io_bus.tx_rdy) begin
              r_tx_en     <= 1'b1;
              r_tx_data   <= w_first_byte;
              r_last_term <= w_term && (r_wptr == '0);
              r_state     <= S_WAIT_BUSY;
            end else begin
              r_state     <= S_SEND;
            end
          end
        end

        S_SEND: begin
          if (io_bus.tx_rdy) begin
            r_tx_en     <= 1'b1;
            r_tx_data   <= w_rd_hit ? w_rd_byte : TERM;
            r_last_term <= !w_rd_hit;
            r_state     <= S_WAIT_BUSY;
          end
        end

        // rdy may still read high the cycle after en; wait for it to drop.
        S_WAIT_BUSY: begin
          if (!io_bus.tx_rdy) r_state <= S_WAIT_RDY;
        end

        S_WAIT_RDY: begin
          if (io_bus.tx_rdy) begin
            if (r_last_term) begin
              r_wptr  <= '0;
              r_rptr  <= '0;
              r_state <= S_RECV;
            end else begin
              r_rptr  <= r_rptr + ONE_P;
              r_state <= S_SEND;
            end
          end
        end

        default: r_state <= S_RECV;
      endcase
    end
  end

  assign io_bus.tx_en   = r_tx_en;
  assign io_bus.tx_data = r_tx_data;
  assign io_bus.busy    = !w_recv;
  assign io_bus.dropped = r_dropped;
  assign io_bus.fill    = r_wptr;
endmodule

// File: tb/tb_uart_line_buffer.sv
// tb_uart_line_buffer
//   Bench for uart_line_buffer: drives receiver strobes, models the UART
//   transmitter handshake and scores transmitted bytes against a queue of
//   expected bytes filled as stimulus is driven.
module tb_uart_line_buffer;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  uart_line_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_line_buffer #(.DEPTH(DEPTH), .TERM(8'h0D)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_en   = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Transmitter model and output monitor: rdy drops for a few cycles after
  // each en, every en is scored against the expected queue.
  initial begin
    int   cnt;
    logic prev_en;
    bus.tx_rdy = 1'b1;
    cnt        = 0;
    prev_en    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_en === 1'b1) begin
        n_en++;
        chk("en_while_rdy", {31'd0, bus.tx_rdy}, 32'd1);
        chk("en_consecutive", {31'd0, prev_en}, 32'd0);
        if (exp_q.size() == 0) chk("tx_unexpected", exp_q.size(), 1);
        else chk("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
        bus.tx_rdy = 1'b0;
        cnt        = 3;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.tx_rdy = 1'b1;
      end
      prev_en = bus.tx_en;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((bus.busy !== 1'b0 || exp_q.size() != 0) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("idle_reached", {31'd0, bus.busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int en0;
    int snap;
    int i;
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset held 3 cycles with rx_valid toggling
    repeat (3) begin
      @(negedge clk);
      bus.rx_valid = ~bus.rx_valid;
      bus.rx_data  = 8'h0D;
    end
    @(negedge clk);
    chk("rst_tx_en",   {31'd0, bus.tx_en},   32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_dropped", {31'd0, bus.dropped}, 32'd0);
    chk("rst_fill",    {27'd0, bus.fill},    32'd0);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Line echo "go\r"
    en0 = n_en;
    exp_q.push_back(8'h67); send_byte(8'h67);
    chk("echo_fill1", {27'd0, bus.fill}, 32'd1);
    exp_q.push_back(8'h6F); send_byte(8'h6F);
    chk("echo_fill2", {27'd0, bus.fill}, 32'd2);
    exp_q.push_back(8'h0D); send_byte(8'h0D);
    chk("term_busy", {31'd0, bus.busy},  32'd1);
    chk("term_en",   {31'd0, bus.tx_en}, 32'd1);
    wait_idle();
    chk("echo_en_count", n_en - en0, 3);
    chk("echo_dropped", {31'd0, bus.dropped}, 32'd0);
    chk("echo_fill_end", {27'd0, bus.fill}, 32'd0);

    // Full buffer without terminator
    en0 = n_en;
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(8'h41 + 8'(k));
      send_byte(8'h41 + 8'(k));
      if (k == DEPTH - 2) begin
        chk("full_busy_pre", {31'd0, bus.busy}, 32'd0);
        chk("full_fill_pre", {27'd0, bus.fill}, 32'd15);
      end
    end
    exp_q.push_back(8'h0D);
    chk("full_fill16", {27'd0, bus.fill},  32'd16);
    chk("full_busy",   {31'd0, bus.busy},  32'd1);
    chk("full_en",     {31'd0, bus.tx_en}, 32'd1);
    wait_idle();
    chk("full_en_count", n_en - en0, 17);
    chk("full_fill_end", {27'd0, bus.fill}, 32'd0);
    chk("full_dropped", {31'd0, bus.dropped}, 32'd0);

    // Empty line
    en0 = n_en;
    exp_q.push_back(8'h0D); send_byte(8'h0D);
    wait_idle();
    chk("empty_en_count", n_en - en0, 1);

    // Drop during replay
    en0 = n_en;
    exp_q.push_back(8'h61); send_byte(8'h61);
    exp_q.push_back(8'h62); send_byte(8'h62);
    exp_q.push_back(8'h0D); send_byte(8'h0D);
    chk("drop_busy", {31'd0, bus.busy}, 32'd1);
    send_byte(8'h7A);
    chk("drop_set", {31'd0, bus.dropped}, 32'd1);
    wait_idle();
    chk("drop_sticky", {31'd0, bus.dropped}, 32'd1);
    chk("drop_en_count", n_en - en0, 3);

    // Reset after the 2nd tx_en of a 5-byte line
    en0 = n_en;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h31 + 8'(k));
      send_byte(8'h31 + 8'(k));
    end
    exp_q.push_back(8'h0D); send_byte(8'h0D);
    i = 0;
    while (n_en < en0 + 2 && i < 500) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("mid_second_en", n_en - en0, 2);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    snap = n_en;
    repeat (30) @(negedge clk);
    chk("mid_no_more_en", n_en - snap, 0);
    chk("mid_fill",    {27'd0, bus.fill},    32'd0);
    chk("mid_busy",    {31'd0, bus.busy},    32'd0);
    chk("mid_dropped", {31'd0, bus.dropped}, 32'd0);

    // Next line after reset
    en0 = n_en;
    exp_q.push_back(8'h68); send_byte(8'h68);
    exp_q.push_back(8'h0D); send_byte(8'h0D);
    wait_idle();
    chk("post_en_count", n_en - en0, 2);
    chk("post_fill", {27'd0, bus.fill}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_line_buffer.md
# uart_line_buffer

Line-oriented byte buffer between the UART receiver and the UART transmitter in `top`. Collects bytes from the receiver's `valid`/`data_out` stream into an internal buffer until a carriage return (0x0D) arrives or the buffer fills. Then replays the whole line, followed by the terminator, through the transmitter's `en`/`rdy` handshake. Gives the board a line-echo path and a staging point for future command parsing.

## Interface
- `DEPTH`, 16: buffer capacity in bytes; power of two, 2..256.
- `TERM`, 8'h0D: byte value that closes a line.
- `clk`  in  1  system clock, same clock as the UART rx/tx.
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `rx_valid`  in  1  one-cycle strobe from the receiver; `rx_data` is valid this cycle.
- `rx_data`  in  8  received byte.
- `tx_rdy`  in  1  transmitter idle and able to accept a byte.
- `tx_en`  out  1  one-cycle strobe; transmitter latches `tx_data`.
- `tx_data`  out  8  byte to transmit; stable from the `tx_en` cycle until the next `tx_en`.
- `busy`  out  1  high while a line is being replayed (any state other than RECV).
- `dropped`  out  1  sticky; set when a received byte was discarded; cleared only by reset.
- `fill`  out  $clog2(DEPTH)+1  number of bytes currently stored.

## Operation
- Storage: `DEPTH`×8 register array, write pointer `wptr`, read pointer `rptr`; `fill` equals `wptr` in RECV.
- **RECV** (reset state):
  - On `rx_valid` with `rx_data != TERM` and `fill < DEPTH`: store the byte at `wptr` and increment `wptr`.
  - On `rx_valid` with `rx_data == TERM`: the terminator is not stored. Set `rptr = 0` and go to SEND.
  - When `fill` reaches `DEPTH` after a store: go to SEND. The replay still appends `TERM`.
  - Empty line (`TERM` with `fill == 0`): go to SEND and transmit only `TERM`.
- **SEND**:
  - When `tx_rdy == 1`, assert `tx_en` for one cycle.
  - `tx_data` = buffer[`rptr`] if `rptr < wptr`, else `TERM`.
  - Go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `tx_rdy == 0`, then go to WAIT_RDY. This guards against a stale `rdy` in the cycle after `en`.
- **WAIT_RDY**: wait for `tx_rdy == 1`.
  - If the byte just sent was `TERM`: clear `wptr`, `rptr` and `fill`, then go to RECV.
  - Otherwise: increment `rptr` and go to SEND.
- Any `rx_valid` outside RECV, or in RECV with `fill == DEPTH`, discards the byte and sets `dropped`.
- Pointer width is $clog2(DEPTH)+1, so `fill == DEPTH` is distinguishable from 0. Pointers never wrap; they are cleared at end of line.

## Timing
- Reset values: `tx_en=0`, `tx_data=8'h00`, `busy=0`, `dropped=0`, `fill=0`, state RECV, pointers 0.
- Reset mid-line or mid-replay:
  - Abandons the line and returns to RECV with the buffer empty.
  - A byte already handed to the transmitter is not recalled.
- Store latency: a byte on `rx_valid` at cycle N is counted in `fill` at N+1.
- Terminator to first `tx_en`:
  - With `tx_rdy` already high, `TERM` strobe at cycle N gives `tx_en` at N+1 (registered) and `busy` high from N+1.
  - Otherwise `tx_en` is asserted in the first cycle after N+1 in which `tx_rdy` is high.
- `tx_en` is registered, never asserted in two consecutive cycles, and never asserted while `tx_rdy == 0`.
- Last byte: `busy` falls the cycle after `tx_rdy` returns high following the `TERM` transmission. RECV accepts `rx_valid` in that same cycle.
- `rx_valid` coinciding with the RECV→SEND transition: the cycle that transitions is the terminator/full cycle itself. The next strobe is processed in SEND and dropped.

## Test plan
- Reset: hold `rst=0` for 3 cycles with `rx_valid` toggling → all outputs at reset values, `fill=0`.
- Line echo: receive "g","o",0x0D with `tx_rdy` modelled by the transmitter → `tx_data` sequence 0x67,0x6F,0x0D. There are exactly 3 `tx_en` pulses, each while `tx_rdy=1`. `busy` is low afterwards and `dropped=0`.
- Full buffer: receive 16 bytes 0x41..0x50 without a terminator → SEND entered after the 16th byte and 17 bytes transmitted (0x41..0x50, then 0x0D). `fill` is 16 before replay and 0 after.
- Drop during replay: send byte 0x7A while `busy=1` → `dropped=1` and stays 1, and 0x7A is never transmitted.
- Empty line: single 0x0D → one `tx_en` with `tx_data=0x0D`.
- Mid-replay reset: assert `rst=0` after the 2nd `tx_en` of a 5-byte line → no further `tx_en`, `fill=0`, `busy=0`. The next line "h",0x0D echoes correctly.
